fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Write-side scheduler for the async FIFO write port. It shares the single write port
//  (wr_inc/wr_data into the write-pointer/full logic and RAM) among NUM_REQ requesters.
//  Arbitration is round-robin with bounded bursts, and writes are held off while full is high.
//  Sits in the wr_clk domain between the producer clients and the FIFO write pointer.
// PARAMETERS
//  NUM_REQ    4  number of requesters (>=2)
//  DATA_W     8  write data width
//  MAX_BURST  4  max accepted beats per grant (>=1)
// PORTS
//  wr_clk     in   1                write clock; the only clock
//  wr_rst     in   1                reset, asynchronous, active-high
//  req        in   NUM_REQ          per-requester write request (level, held while data valid)
//  req_data   in   NUM_REQ*DATA_W   packed data; slice i = [i*DATA_W +: DATA_W]
//  req_last   in   NUM_REQ          marks current beat as last of requester's burst
//  full       in   1                FIFO full flag from write-pointer logic
//  gnt        out  NUM_REQ          one-hot grant, registered
//  cur_id     out  $clog2(NUM_REQ)  index of granted requester, registered
//  busy       out  1                1 while in GRANT state
//  wr_inc     out  1                write enable to FIFO
//  wr_data    out  DATA_W           write data to FIFO RAM
// BEHAVIOUR
//  - Reset (async, wr_rst=1):
//    - State and outputs: state=IDLE, gnt=0, cur_id=0, busy=0, wr_inc=0, beat_cnt=0.
//    - last_id=NUM_REQ-1, so requester 0 has first priority.
//  - IDLE:
//    - If |req, pick the first asserted req scanning from last_id+1 upward, modulo NUM_REQ.
//    - Register gnt/cur_id to the winner, clear beat_cnt, go to GRANT.
//    - If no req, stay in IDLE.
//  - GRANT:
//    - wr_inc = req[cur_id] & ~full (combinational from registered state).
//    - wr_data = req_data slice cur_id. It is don't-care when wr_inc=0.
//    - Accepted beat = wr_inc=1 at a rising wr_clk edge. On each accepted beat, beat_cnt increments.
//  - Burst end: go to IDLE, set last_id=cur_id, clear gnt. This happens on any of:
//    - an accepted beat with req_last[cur_id]=1;
//    - an accepted beat with beat_cnt==MAX_BURST-1;
//    - req[cur_id]=0 (requester withdrew; no write that cycle).
//  - Timing:
//    - Grant latency: req seen in IDLE at edge k gives gnt valid after edge k.
//    - First write can be accepted at edge k+1.
//    - One IDLE bubble cycle between consecutive bursts.
//  - full=1 in GRANT:
//    - wr_inc=0; gnt, cur_id and beat_cnt hold; no timeout (stall until full drops).
//  - Simultaneous events:
//    - full=1 together with req_last: no accept, burst continues.
//    - Withdrawal takes precedence over full.
//  - Requests on non-granted lines are ignored until the next IDLE arbitration; no queueing.
//  - beat_cnt width: $clog2(MAX_BURST+1); never exceeds MAX_BURST-1 (wrap impossible).
//  - Reset mid-burst: gnt and wr_inc drop immediately (async). The partial burst is abandoned.
//  - busy=1 exactly when state==GRANT.
// STRUCTURE
//  - Package fifo_arb_pkg: state enum {IDLE, GRANT}; localparam widths ID_W=$clog2(NUM_REQ),
//    CNT_W=$clog2(MAX_BURST+1).
//  - Sub-module rr_pick: combinational round-robin picker.
//    - Inputs: req, last_id. Outputs: onehot, idx, any.
//  - Top holds the FSM, beat counter, last_id register and data mux.
// TESTING
//  - Reset: wr_rst=1 with req=4'b1111 -> gnt=0, wr_inc=0, busy=0.
//    Release, req=4'b0001 -> gnt=4'b0001 after next edge; wr_inc=1 the following cycle.
//  - Round-robin: req=4'b1111 held, full=0, MAX_BURST=4, no req_last -> grant order 0,1,2,3,0.
//    Exactly 4 writes per grant; 16 writes in 20 cycles.
//  - Full stall: full=1 for 3 cycles after beat 2 of requester 1 -> wr_inc=0, gnt=4'b0010 held.
//    Burst resumes and totals exactly 4 writes.
//  - Early end: requester 2 asserts req_last on its 2nd accepted beat -> 2 writes only.
//    Next grant goes to requester 3 after one IDLE cycle.
//  - Withdrawal / simultaneous: requester 0 drops req mid-burst -> no write that cycle, IDLE next.
//    Separately, full=1 with req_last=1 -> no write, burst continues.
//  - Async reset mid-burst: wr_rst pulsed between edges -> gnt, wr_inc, busy go 0 without a clock edge.
//    After release with req=4'b1010 -> requester 1 granted first.
//    Scoreboard: per-requester write count and data order match stimulus throughout.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int NUM_REQ_DEF   = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int MAX_BURST_DEF = 4;

    localparam int ID_W  = $clog2(NUM_REQ_DEF);
    localparam int CNT_W = $clog2(MAX_BURST_DEF + 1);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after
// last_id, wrapping modulo NUM_REQ, so last_id itself has lowest priority.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_id,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IW-1:0]      idx,
    output logic               any
);

    localparam int SUM_W = IW + 1;

    logic             found;
    logic [SUM_W-1:0] sum;
    logic [IW-1:0]    cand;

    // Scan offsets 1..NUM_REQ from last_id, keep the first hit.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        sum    = '0;
        cand   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            sum  = {1'b0, last_id} + SUM_W'(off);
            cand = (sum >= SUM_W'(NUM_REQ)) ? IW'(sum - SUM_W'(NUM_REQ)) : IW'(sum);
            if (!found && req[cand]) begin
                found        = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side scheduler for the async FIFO: shares the single write port among
// NUM_REQ producers, round-robin with bounded bursts, stalling while full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                        wr_clk,
    input  logic                        wr_rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic                        full,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [$clog2(NUM_REQ)-1:0]  cur_id,
    output logic                        busy,
    output logic                        wr_inc,
    output logic [DATA_W-1:0]           wr_data
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BCNT_W = $clog2(MAX_BURST + 1);

    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

    arb_state_t         state, state_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [IDX_W-1:0]   cur_id_nxt;
    logic [IDX_W-1:0]   last_id, last_id_nxt;
    logic [BCNT_W-1:0]  beat_cnt, beat_cnt_nxt;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic cur_req;
    logic cur_last;
    logic burst_end;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IDX_W)
    ) u_pick (
        .req     (req),
        .last_id (last_id),
        .onehot  (pick_onehot),
        .idx     (pick_idx),
        .any     (pick_any)
    );

    assign cur_req  = req[cur_id];
    assign cur_last = req_last[cur_id];

    // Write strobe comes straight from registered state so reset kills it at once.
    assign wr_inc  = (state == GRANT) && cur_req && !full;
    assign wr_data = req_data[cur_id*DATA_W +: DATA_W];
    assign busy    = (state == GRANT);

    // State register.
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath next values; withdrawal is checked before full.
    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        cur_id_nxt   = cur_id;
        last_id_nxt  = last_id;
        beat_cnt_nxt = beat_cnt;
        burst_end    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt    = GRANT;
                    gnt_nxt      = pick_onehot;
                    cur_id_nxt   = pick_idx;
                    beat_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (!cur_req) begin
                    burst_end = 1'b1;
                end else if (wr_inc) begin
                    if (cur_last || (beat_cnt == LAST_BEAT)) begin
                        burst_end = 1'b1;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 1'b1;
                    end
                end
                if (burst_end) begin
                    state_nxt    = IDLE;
                    gnt_nxt      = '0;
                    last_id_nxt  = cur_id;
                    beat_cnt_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, current id, round-robin pointer and beat counter registers.
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            gnt      <= '0;
            cur_id   <= '0;
            last_id  <= LAST_IDX;
            beat_cnt <= '0;
        end else begin
            gnt      <= gnt_nxt;
            cur_id   <= cur_id_nxt;
            last_id  <= last_id_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus multi-cycle sequences.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N  = NUM_REQ_DEF;
    localparam int DW = DATA_W_DEF;

    logic              wr_clk = 1'b0;
    logic              wr_rst;
    logic [N-1:0]      req;
    logic [N-1:0]      req_last;
    logic [N*DW-1:0]   req_data;
    logic              full;
    logic [N-1:0]      gnt;
    logic [ID_W-1:0]   cur_id;
    logic              busy;
    logic              wr_inc;
    logic [DW-1:0]     wr_data;

    fifo_wr_arbiter dut (
        .wr_clk   (wr_clk),
        .wr_rst   (wr_rst),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .full     (full),
        .gnt      (gnt),
        .cur_id   (cur_id),
        .busy     (busy),
        .wr_inc   (wr_inc),
        .wr_data  (wr_data)
    );

    always #5 wr_clk = ~wr_clk;

    int checks   = 0;
    int failures = 0;
    int wr_cnt[N];
    int total_wr;
    int gnt_log[$];

    logic [N-1:0]    obs_gnt, prev_gnt;
    logic            obs_inc, obs_busy;
    logic [ID_W-1:0] obs_id;
    logic [DW-1:0]   obs_data;

    typedef struct {
        logic         rst;
        logic [N-1:0] r;
        logic [N-1:0] l;
        logic         f;
        logic [N-1:0] eg;
        logic         ei;
        logic         eb;
        int           eid;
    } vec_t;

    vec_t vt[9];
    int   exp_order[5];

    // Each producer presents {its id, number of its beats accepted so far}.
    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = {i[1:0], wr_cnt[i][5:0]};
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Apply inputs at negedge, sample just after, then let the posedge happen.
    task automatic step(input logic rst, input logic [N-1:0] r, input logic [N-1:0] l, input logic f);
        @(negedge wr_clk);
        wr_rst = rst; req = r; req_last = l; full = f;
        #1;
        obs_gnt = gnt; obs_inc = wr_inc; obs_busy = busy; obs_id = cur_id; obs_data = wr_data;
        if (obs_busy) chk("gnt_vs_id", int'(obs_gnt), 1 << obs_id);
        if (obs_inc) chk("wr_data", int'(obs_data), int'({obs_id, wr_cnt[obs_id][5:0]}));
        if (obs_gnt != '0 && prev_gnt == '0) gnt_log.push_back(oh_idx(obs_gnt));
        prev_gnt = obs_gnt;
        @(posedge wr_clk);
        if (obs_inc && !rst) begin
            wr_cnt[obs_id]++;
            total_wr++;
        end
    endtask

    task automatic reset_dut();
        step(1'b1, '0, '0, 1'b0);
        step(1'b1, '0, '0, 1'b0);
        for (int i = 0; i < N; i++) wr_cnt[i] = 0;
        total_wr = 0;
        gnt_log.delete();
        prev_gnt = '0;
    endtask

    initial begin
        wr_rst = 1'b1; req = '0; req_last = '0; full = 1'b0;
        for (int i = 0; i < N; i++) wr_cnt[i] = 0;
        total_wr = 0;
        prev_gnt = '0;

        //          rst   req      last     full  gnt      inc   busy  id
        vt[0] = '{1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 0};
        vt[1] = '{1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 0};
        vt[2] = '{1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b1, 0};
        vt[3] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0, 1'b1, 0};
        vt[4] = '{1'b0, 4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 0};
        vt[5] = '{1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 0};
        vt[6] = '{1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b1, 0};
        vt[7] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b1, 0};
        vt[8] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 0};
        exp_order = '{0, 1, 2, 3, 0};

        for (int i = 0; i < 9; i++) begin
            step(vt[i].rst, vt[i].r, vt[i].l, vt[i].f);
            chk($sformatf("vec%0d_gnt", i), int'(obs_gnt), int'(vt[i].eg));
            chk($sformatf("vec%0d_wr_inc", i), int'(obs_inc), int'(vt[i].ei));
            chk($sformatf("vec%0d_busy", i), int'(obs_busy), int'(vt[i].eb));
            chk($sformatf("vec%0d_cur_id", i), int'(obs_id), vt[i].eid);
        end
        chk("vec_writes_req0", wr_cnt[0], 3);

        // Round-robin with all requesters active.
        reset_dut();
        for (int c = 0; c < 20; c++) step(1'b0, 4'b1111, 4'b0000, 1'b0);
        chk("rr_total_writes", total_wr, 16);
        for (int i = 0; i < N; i++) chk($sformatf("rr_writes_req%0d", i), wr_cnt[i], 4);
        step(1'b0, 4'b1111, 4'b0000, 1'b0);
        step(1'b0, 4'b1111, 4'b0000, 1'b0);
        chk("rr_grant_count", gnt_log.size(), 5);
        if (gnt_log.size() == 5)
            for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), gnt_log[i], exp_order[i]);

        // Full stall after beat 2 of requester 1.
        reset_dut();
        step(1'b0, 4'b0010, 4'b0000, 1'b0);
        chk("stall_idle_busy", int'(obs_busy), 0);
        for (int c = 0; c < 2; c++) begin
            step(1'b0, 4'b0010, 4'b0000, 1'b0);
            chk("stall_pre_inc", int'(obs_inc), 1);
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 4'b0010, 4'b0000, 1'b1);
            chk("stall_full_inc", int'(obs_inc), 0);
            chk("stall_full_gnt", int'(obs_gnt), 2);
            chk("stall_full_id", int'(obs_id), 1);
        end
        for (int c = 0; c < 2; c++) begin
            step(1'b0, 4'b0010, 4'b0000, 1'b0);
            chk("stall_post_inc", int'(obs_inc), 1);
        end
        step(1'b0, 4'b0010, 4'b0000, 1'b0);
        chk("stall_end_gnt", int'(obs_gnt), 0);
        chk("stall_writes_req1", wr_cnt[1], 4);

        // Early end via req_last on requester 2's second beat.
        reset_dut();
        step(1'b0, 4'b1100, 4'b0000, 1'b0);
        step(1'b0, 4'b1100, 4'b0000, 1'b0);
        chk("early_gnt", int'(obs_gnt), 4);
        step(1'b0, 4'b1100, 4'b0100, 1'b0);
        chk("early_last_inc", int'(obs_inc), 1);
        step(1'b0, 4'b1100, 4'b0000, 1'b0);
        chk("early_bubble_busy", int'(obs_busy), 0);
        step(1'b0, 4'b1100, 4'b0000, 1'b0);
        chk("early_next_gnt", int'(obs_gnt), 8);
        chk("early_next_id", int'(obs_id), 3);
        chk("early_writes_req2", wr_cnt[2], 2);

        // Asynchronous reset between edges, mid-burst.
        reset_dut();
        step(1'b0, 4'b1111, 4'b0000, 1'b0);
        step(1'b0, 4'b1111, 4'b0000, 1'b0);
        @(negedge wr_clk);
        req = 4'b1111; req_last = '0; full = 1'b0;
        #1;
        chk("arst_pre_inc", int'(wr_inc), 1);
        #1 wr_rst = 1'b1;
        #1;
        chk("arst_gnt", int'(gnt), 0);
        chk("arst_inc", int'(wr_inc), 0);
        chk("arst_busy", int'(busy), 0);
        #1 wr_rst = 1'b0; req = 4'b1010;
        step(1'b0, 4'b1010, 4'b0000, 1'b0);
        chk("arst_regrant_gnt", int'(obs_gnt), 2);
        chk("arst_regrant_id", int'(obs_id), 1);
        chk("arst_writes_req0", wr_cnt[0], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
